// File: rtl/sram_controller.sv
// MEM-stage data-memory controller: splits each 32-bit load/store into two
// 16-bit accesses on an asynchronous SRAM, freezing the pipeline meanwhile.
module sram_controller #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [15:0]       sram_dq,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    localparam int CNT_W = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-2:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       low_half_q;
    logic [31:0]       read_data_q;

    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic [15:0]       dq_out_q, dq_out_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;

    logic              req;
    logic              last;
    logic              active_d;
    logic              last_d;
    logic [31:0]       byte_off;
    logic [ADDR_W-2:0] addr_xlate;
    logic              unused_addr_bits;

    assign req        = wr_en | rd_en;
    assign last       = (cnt_q == CNT_LAST);
    assign byte_off   = address - 32'(BASE_ADDR);
    assign addr_xlate = byte_off[ADDR_W:2];
    assign unused_addr_bits = ^{byte_off[31:ADDR_W+1], byte_off[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    op_wr_d = wr_en;
                    waddr_d = addr_xlate;
                    wdata_d = write_data;
                end
            end
            LOW: begin
                if (last) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // SRAM pins are registered from next-state so strobes never glitch and
    // never follow the request inputs combinationally.
    always_comb begin
        active_d    = (state_d == LOW) || (state_d == HIGH);
        last_d      = (cnt_d == CNT_LAST);
        we_n_d      = ~(active_d & op_wr_d & ~last_d);
        oe_n_d      = ~(active_d & ~op_wr_d);
        dq_oe_d     = active_d & op_wr_d;
        dq_out_d    = (state_d == HIGH) ? wdata_d[31:16] : wdata_d[15:0];
        sram_addr_d = sram_addr_q;
        if (active_d)
            sram_addr_d = {waddr_d, (state_d == HIGH)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            sram_addr_q <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            dq_oe_q     <= dq_oe_d;
            sram_addr_q <= sram_addr_d;
            if (state_q == HIGH && last && !op_wr_q)
                read_data_q <= {sram_dq, low_half_q};
        end
    end

    always_ff @(posedge clk) begin
        waddr_q  <= waddr_d;
        wdata_q  <= wdata_d;
        dq_out_q <= dq_out_d;
        if (state_q == LOW && last && !op_wr_q)
            low_half_q <= sram_dq;
    end

    assign ready     = (state_q == DONE) || (state_q == IDLE && !req);
    assign read_data = read_data_q;
    assign sram_addr = sram_addr_q;
    assign sram_we_n = we_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_dq   = dq_oe_q ? dq_out_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small asynchronous SRAM model.
module tb_sram_controller;

    localparam int ADDR_W = 18;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic              rd_en;
    logic [31:0]       address;
    logic [31:0]       write_data;
    logic [31:0]       read_data;
    logic              ready;
    logic [ADDR_W-1:0] sram_addr;
    wire  [15:0]       sram_dq;
    logic              sram_we_n;
    logic              sram_oe_n;

    logic [15:0] mem [0:255];
    int n_cmp = 0;
    int n_bad = 0;

    sram_controller #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2), .BASE_ADDR(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq    (sram_dq),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
    );

    // Undriven bus reads as all-ones, so a floating dq shows up as 16'hFFFF.
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (sram_dq[i]);
    end

    assign sram_dq = (!sram_oe_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

    always @(posedge clk)
        if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts just after a rising edge with the DUT in IDLE; checks every cycle
    // of the op, t (request) through t+5 (DONE).
    task automatic run_op(input string tag, input bit wr, input bit rd,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] lo, input bit exp_wr,
                          input logic [31:0] exp_rd, input bit perturb,
                          input bit idle_after);
        logic [31:0] exp_dq;
        wr_en = wr; rd_en = rd; address = addr; write_data = wd;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("%s_c%0d_ready", tag, c), 32'(ready), (c == 5) ? 32'd1 : 32'd0);
            if (c >= 1 && c <= 4) begin
                chk($sformatf("%s_c%0d_addr", tag, c), 32'(sram_addr), lo + ((c >= 3) ? 32'd1 : 32'd0));
                chk($sformatf("%s_c%0d_we_n", tag, c), 32'(sram_we_n),
                    (exp_wr && (c == 1 || c == 3)) ? 32'd0 : 32'd1);
                chk($sformatf("%s_c%0d_oe_n", tag, c), 32'(sram_oe_n), exp_wr ? 32'd1 : 32'd0);
                if (exp_wr) begin
                    exp_dq = (c < 3) ? {16'h0, wd[15:0]} : {16'h0, wd[31:16]};
                    chk($sformatf("%s_c%0d_dq", tag, c), 32'(sram_dq), exp_dq);
                end
            end else begin
                chk($sformatf("%s_c%0d_we_n", tag, c), 32'(sram_we_n), 32'd1);
                chk($sformatf("%s_c%0d_oe_n", tag, c), 32'(sram_oe_n), 32'd1);
            end
            if (c == 5) begin
                chk($sformatf("%s_done_rdata", tag), read_data, exp_rd);
                chk($sformatf("%s_done_dq", tag), 32'(sram_dq), 32'h0000FFFF);
            end
            @(posedge clk); #1;
            if (c == 0 && perturb) begin
                wr_en = 1'b0; rd_en = 1'b0; address = 32'd2000; write_data = 32'h0;
            end
        end
        if (idle_after) begin
            wr_en = 1'b0; rd_en = 1'b0;
            @(negedge clk);
            chk($sformatf("%s_idle_ready", tag), 32'(ready), 32'd1);
            chk($sformatf("%s_idle_rdata", tag), read_data, exp_rd);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b1; rd_en = 1'b0;
        address = 32'd0; write_data = 32'd0;

        // Reset with a pending store
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_dq", 32'(sram_dq), 32'h0000FFFF);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        @(posedge clk); #1;
        wr_en = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel_we_n", 32'(sram_we_n), 32'd1);
        chk("rel_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rel_dq", 32'(sram_dq), 32'h0000FFFF);
        @(posedge clk); #1;

        run_op("store", 1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 32'd4, 1'b1, 32'h0, 1'b0, 1'b1);
        run_op("load", 1'b0, 1'b1, 32'd1032, 32'h0, 32'd4, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
        run_op("both", 1'b1, 1'b1, 32'd1024, 32'h12345678, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
        run_op("pert", 1'b1, 1'b0, 32'd1036, 32'hA5A55A5A, 32'd6, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        run_op("pert_ld", 1'b0, 1'b1, 32'd1036, 32'h0, 32'd6, 1'b0, 32'hA5A55A5A, 1'b0, 1'b1);

        // Reset during the HIGH half of a store
        wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("mid_we_n_before", 32'(sram_we_n), 32'd0);
        wr_en = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("mid_we_n", 32'(sram_we_n), 32'd1);
        chk("mid_oe_n", 32'(sram_oe_n), 32'd1);
        chk("mid_dq", 32'(sram_dq), 32'h0000FFFF);
        chk("mid_ready", 32'(ready), 32'd1);
        chk("mid_addr", 32'(sram_addr), 32'd0);
        chk("mid_rdata", read_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;

        run_op("b2b_ld", 1'b0, 1'b1, 32'd1024, 32'h0, 32'd0, 1'b0, 32'h12345678, 1'b0, 1'b0);
        run_op("b2b_st", 1'b1, 1'b0, 32'd1032, 32'h0BADF00D, 32'd4, 1'b1, 32'h12345678, 1'b0, 1'b1);
        run_op("final_ld", 1'b0, 1'b1, 32'd1032, 32'h0, 32'd4, 1'b0, 32'h0BADF00D, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
